// File: rtl/fetch_decode_pipe_if.sv
// Signal bundle between the front-end register bank and its neighbours:
// hazard unit controls, instruction memory, decode results and the E-stage view.
interface fetch_decode_pipe_if #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 10
);
  // Hazard unit and execute-stage redirect
  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic              PCSrcE;
  logic [XLEN-1:0]   PCTargetE;
  // Instruction memory and decode inputs
  logic [31:0]       InstrF;
  logic [XLEN-1:0]   RD1D;
  logic [XLEN-1:0]   RD2D;
  logic [XLEN-1:0]   ImmExtD;
  logic [CTRL_W-1:0] CtrlD;
  // Fetch and IF/ID outputs
  logic [XLEN-1:0]   PCF;
  logic [31:0]       InstrD;
  logic [XLEN-1:0]   PCD;
  logic [XLEN-1:0]   PCPlus4D;
  logic [4:0]        Rs1D;
  logic [4:0]        Rs2D;
  logic [4:0]        RdD;
  logic              ValidD;
  // ID/EX outputs
  logic              ValidE;
  logic [4:0]        Rs1E;
  logic [4:0]        Rs2E;
  logic [4:0]        RdE;
  logic [XLEN-1:0]   RD1E;
  logic [XLEN-1:0]   RD2E;
  logic [XLEN-1:0]   ImmExtE;
  logic [XLEN-1:0]   PCE;
  logic [XLEN-1:0]   PCPlus4E;
  logic [CTRL_W-1:0] CtrlE;
  // Performance counters
  logic [31:0]       StallCount;
  logic [31:0]       FlushCount;

  // Surrounding core: drives controls and stage inputs, observes the registers
  modport master (
    output StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE,
    output InstrF, RD1D, RD2D, ImmExtD, CtrlD,
    input  PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD,
    input  ValidE, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, CtrlE,
    input  StallCount, FlushCount
  );

  // Register bank: consumes controls and stage inputs, owns the registers
  modport slave (
    input  StallF, StallD, FlushD, FlushE, PCSrcE, PCTargetE,
    input  InstrF, RD1D, RD2D, ImmExtD, CtrlD,
    output PCF, InstrD, PCD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD,
    output ValidE, Rs1E, Rs2E, RdE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, CtrlE,
    output StallCount, FlushCount
  );
endinterface

// File: rtl/fetch_decode_pipe.sv
// Front-end pipeline register bank of the 5-stage core: fetch PC, IF/ID and
// ID/EX registers, driven by the hazard unit's stall/flush controls and the
// E-stage branch redirect. Also counts stall and redirect events.
// XLEN/CTRL_W must match the parameters of the connected interface instance.
module fetch_decode_pipe #(
  parameter int              XLEN     = 32,
  parameter int              CTRL_W   = 10,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic               clk,
  input logic               reset,
  fetch_decode_pipe_if.slave bus
);

  // addi x0,x0,0: all register fields zero, so a bubble never matches a hazard
  localparam logic [31:0]     NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  // Fetch stage
  logic [XLEN-1:0]   pc_p0;
  logic [XLEN-1:0]   pcPlus4_p0;
  logic [XLEN-1:0]   pcNext_p0;

  // IF/ID register
  logic [31:0]       instr_p1;
  logic [XLEN-1:0]   pc_p1;
  logic [XLEN-1:0]   pcPlus4_p1;
  logic              vld_p1;

  // ID/EX register
  logic [4:0]        rs1_p2;
  logic [4:0]        rs2_p2;
  logic [4:0]        rd_p2;
  logic [XLEN-1:0]   rd1_p2;
  logic [XLEN-1:0]   rd2_p2;
  logic [XLEN-1:0]   imm_p2;
  logic [XLEN-1:0]   pc_p2;
  logic [XLEN-1:0]   pcPlus4_p2;
  logic [CTRL_W-1:0] ctrl_p2;
  logic              vld_p2;

  logic [31:0]       stallCnt;
  logic [31:0]       flushCnt;

  assign pcPlus4_p0 = pc_p0 + PC_INC;

  // ---- stage 0: fetch PC ----
  // Next PC: redirect beats stall, otherwise sequential (wraps silently)
  always_comb begin
    pcNext_p0 = pcPlus4_p0;
    if (bus.PCSrcE) begin
      pcNext_p0 = bus.PCTargetE;
    end else if (bus.StallF) begin
      pcNext_p0 = pc_p0;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0 <= RESET_PC;
    end else begin
      pc_p0 <= pcNext_p0;
    end
  end

  // ---- stage 1: IF/ID ----
  // Flush beats stall; a held bubble stays a bubble because ValidD is held too
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_p1   <= NOP;
      pc_p1      <= '0;
      pcPlus4_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (bus.FlushD) begin
      instr_p1   <= NOP;
      pc_p1      <= '0;
      pcPlus4_p1 <= '0;
      vld_p1     <= 1'b0;
    end else if (!bus.StallD) begin
      instr_p1   <= bus.InstrF;
      pc_p1      <= pc_p0;
      pcPlus4_p1 <= pcPlus4_p0;
      vld_p1     <= 1'b1;
    end
  end

  // ---- stage 2: ID/EX ----
  // Never stalled; a flush zeroes everything so CtrlE carries no write enables
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs1_p2     <= '0;
      rs2_p2     <= '0;
      rd_p2      <= '0;
      rd1_p2     <= '0;
      rd2_p2     <= '0;
      imm_p2     <= '0;
      pc_p2      <= '0;
      pcPlus4_p2 <= '0;
      ctrl_p2    <= '0;
      vld_p2     <= 1'b0;
    end else if (bus.FlushE) begin
      rs1_p2     <= '0;
      rs2_p2     <= '0;
      rd_p2      <= '0;
      rd1_p2     <= '0;
      rd2_p2     <= '0;
      imm_p2     <= '0;
      pc_p2      <= '0;
      pcPlus4_p2 <= '0;
      ctrl_p2    <= '0;
      vld_p2     <= 1'b0;
    end else begin
      rs1_p2     <= instr_p1[19:15];
      rs2_p2     <= instr_p1[24:20];
      rd_p2      <= instr_p1[11:7];
      rd1_p2     <= bus.RD1D;
      rd2_p2     <= bus.RD2D;
      imm_p2     <= bus.ImmExtD;
      pc_p2      <= pc_p1;
      pcPlus4_p2 <= pcPlus4_p1;
      ctrl_p2    <= bus.CtrlD;
      vld_p2     <= vld_p1;
    end
  end

  // Event counters: decode stalls and taken redirects, free-running with wrap
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (bus.StallD) stallCnt <= stallCnt + 32'd1;
      if (bus.PCSrcE) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign bus.PCF        = pc_p0;
  assign bus.InstrD     = instr_p1;
  assign bus.PCD        = pc_p1;
  assign bus.PCPlus4D   = pcPlus4_p1;
  assign bus.ValidD     = vld_p1;
  assign bus.Rs1D       = instr_p1[19:15];
  assign bus.Rs2D       = instr_p1[24:20];
  assign bus.RdD        = instr_p1[11:7];
  assign bus.ValidE     = vld_p2;
  assign bus.Rs1E       = rs1_p2;
  assign bus.Rs2E       = rs2_p2;
  assign bus.RdE        = rd_p2;
  assign bus.RD1E       = rd1_p2;
  assign bus.RD2E       = rd2_p2;
  assign bus.ImmExtE    = imm_p2;
  assign bus.PCE        = pc_p2;
  assign bus.PCPlus4E   = pcPlus4_p2;
  assign bus.CtrlE      = ctrl_p2;
  assign bus.StallCount = stallCnt;
  assign bus.FlushCount = flushCnt;

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Testbench for fetch_decode_pipe: reset/free-run checks, a scoreboarded
// random instruction stream, a table of control combinations, and hand
// sequences for bubble hold, async reset and PC wrap.
module tb_fetch_decode_pipe;
  localparam int          XLEN    = 32;
  localparam int          CTRL_W  = 10;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] INSTR_A = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] INSTR_B = 32'h0020_8133;  // add x2,x1,x2

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_decode_pipe_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) bus ();
  fetch_decode_pipe_if #(.XLEN(XLEN), .CTRL_W(CTRL_W)) busW ();

  fetch_decode_pipe #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));

  fetch_decode_pipe #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC(32'hFFFF_FFFC)) dutW (
    .clk(clk), .reset(reset), .bus(busW.slave));

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic [4:0]        rs1, rs2, rd;
    logic [31:0]       pc, rd1, rd2, imm;
    logic [CTRL_W-1:0] ctrl;
  } eRec_t;
  eRec_t sbQ[$];

  typedef struct {
    string       name;
    bit          sF, sD, fD, fE, br;
    logic [31:0] expPcf, expInstrD, expPcD;
    bit          expVD, expVE;
    logic [4:0]  expRdE;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.StallF = 0; bus.StallD = 0; bus.FlushD = 0; bus.FlushE = 0; bus.PCSrcE = 0;
    bus.PCTargetE = '0; bus.InstrF = NOP; bus.RD1D = '0; bus.RD2D = '0;
    bus.ImmExtD = '0; bus.CtrlD = '0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    clearInputs();
    #3;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    eRec_t       rec, got;
    logic [31:0] curInstr, prevInstr, prevPc, expPc;
    logic [31:0] ei;
    bit          prevValid;
    int          pops;

    vecs[0] = '{"none",          0,0,0,0,0, 32'd12,  INSTR_B, 32'd8, 1,1, 5'd1};
    vecs[1] = '{"loaduse",       1,1,0,1,0, 32'd8,   INSTR_A, 32'd4, 1,0, 5'd0};
    vecs[2] = '{"redirect",      1,0,1,1,1, 32'h100, NOP,     32'd0, 0,0, 5'd0};
    vecs[3] = '{"allfive",       1,1,1,1,1, 32'h100, NOP,     32'd0, 0,0, 5'd0};
    vecs[4] = '{"flushD_stallD", 0,1,1,0,0, 32'd12,  NOP,     32'd0, 0,1, 5'd1};
    vecs[5] = '{"stallD",        0,1,0,0,0, 32'd12,  INSTR_A, 32'd4, 1,1, 5'd1};
    vecs[6] = '{"br_stallF",     1,0,0,0,1, 32'h100, INSTR_B, 32'd8, 1,1, 5'd1};
    vecs[7] = '{"flushE",        0,0,0,1,0, 32'd12,  INSTR_B, 32'd8, 1,0, 5'd0};
    vecs[8] = '{"stallF",        1,0,0,0,0, 32'd8,   INSTR_B, 32'd8, 1,1, 5'd1};

    // Wrap instance inputs stay idle
    busW.StallF = 0; busW.StallD = 0; busW.FlushD = 0; busW.FlushE = 0; busW.PCSrcE = 0;
    busW.PCTargetE = '0; busW.InstrF = NOP; busW.RD1D = '0; busW.RD2D = '0;
    busW.ImmExtD = '0; busW.CtrlD = '0;

    // Reset values and free-run
    clearInputs();
    #12;
    check("rst_pcf", bus.PCF, 32'h0);
    check("rst_instrD", bus.InstrD, NOP);
    check("rst_pcD", {bus.PCD, bus.PCPlus4D}, 64'h0);
    check("rst_valid", {bus.ValidD, bus.ValidE}, 2'b00);
    check("rst_eregs", {bus.Rs1E, bus.Rs2E, bus.RdE, bus.CtrlE}, '0);
    check("rst_edata", {bus.RD1E, bus.PCE}, 64'h0);
    check("rst_counts", {bus.StallCount, bus.FlushCount}, 64'h0);
    check("wrap_rst_pcf", busW.PCF, 32'hFFFF_FFFC);
    @(negedge clk);
    reset = 1'b1;
    bus.InstrF = INSTR_A;
    step();
    check("free1_pcf", bus.PCF, 32'd4);
    check("free1_valid", {bus.ValidD, bus.ValidE}, 2'b10);
    check("free1_instrD", bus.InstrD, INSTR_A);
    check("wrap_pcf", busW.PCF, 32'h0);
    step();
    check("free2_pcf", bus.PCF, 32'd8);
    check("free2_validE", bus.ValidE, 1'b1);
    check("free2_rs1E_rdE", {bus.Rs1E, bus.RdE}, {5'd0, 5'd1});
    check("wrap_pcf2", busW.PCF, 32'd4);
    step();
    check("free3_pcf", bus.PCF, 32'd12);

    // Scoreboarded random stream
    doReset();
    expPc = 32'h0; prevValid = 0; pops = 0; prevInstr = NOP; prevPc = '0;
    for (int i = 0; i < 16; i++) begin
      if (prevValid) begin
        rec.rs1 = prevInstr[19:15];
        rec.rs2 = prevInstr[24:20];
        rec.rd  = prevInstr[11:7];
        rec.pc  = prevPc;
        rec.rd1 = $urandom;
        rec.rd2 = $urandom;
        rec.imm = $urandom;
        rec.ctrl = CTRL_W'($urandom);
        bus.RD1D = rec.rd1; bus.RD2D = rec.rd2; bus.ImmExtD = rec.imm; bus.CtrlD = rec.ctrl;
        sbQ.push_back(rec);
      end
      check("stream_pcf", bus.PCF, expPc);
      curInstr = {7'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  3'b000, 5'($urandom_range(0, 31)), 7'h33};
      bus.InstrF = curInstr;
      prevInstr = curInstr; prevPc = expPc; expPc = expPc + 32'd4; prevValid = 1;
      step();
      check("stream_rsD", {bus.Rs1D, bus.Rs2D, bus.RdD},
            {curInstr[19:15], curInstr[24:20], curInstr[11:7]});
      if (bus.ValidE) begin
        if (sbQ.size() == 0) begin
          check("stream_unexpectedE", 1'b1, 1'b0);
        end else begin
          got = sbQ.pop_front();
          pops++;
          check("stream_eregs", {bus.Rs1E, bus.Rs2E, bus.RdE}, {got.rs1, got.rs2, got.rd});
          check("stream_epc", {bus.PCE, bus.PCPlus4E}, {got.pc, got.pc + 32'd4});
          check("stream_ed1d2", {bus.RD1E, bus.RD2E}, {got.rd1, got.rd2});
          check("stream_eimm_ctrl", {bus.ImmExtE, bus.CtrlE}, {got.imm, got.ctrl});
        end
      end
    end
    check("stream_pops", pops, 15);
    check("stream_qempty", sbQ.size(), 0);

    // Table of one-cycle control combinations from a common state
    for (int v = 0; v < 9; v++) begin
      doReset();
      bus.InstrF = INSTR_A;
      step();
      step();
      bus.InstrF = INSTR_B;
      bus.CtrlD = '1;
      bus.PCTargetE = 32'h100;
      bus.StallF = vecs[v].sF; bus.StallD = vecs[v].sD; bus.FlushD = vecs[v].fD;
      bus.FlushE = vecs[v].fE; bus.PCSrcE = vecs[v].br;
      step();
      ei = vecs[v].expInstrD;
      check({vecs[v].name, "_pcf"}, bus.PCF, vecs[v].expPcf);
      check({vecs[v].name, "_instrD"}, bus.InstrD, ei);
      check({vecs[v].name, "_rsD"}, {bus.Rs1D, bus.Rs2D, bus.RdD}, {ei[19:15], ei[24:20], ei[11:7]});
      check({vecs[v].name, "_pcD"}, bus.PCD, vecs[v].expPcD);
      check({vecs[v].name, "_validD"}, bus.ValidD, vecs[v].expVD);
      check({vecs[v].name, "_validE"}, bus.ValidE, vecs[v].expVE);
      check({vecs[v].name, "_rdE"}, bus.RdE, vecs[v].expRdE);
      check({vecs[v].name, "_ctrlE"}, bus.CtrlE, vecs[v].fE ? {CTRL_W{1'b0}} : {CTRL_W{1'b1}});
      check({vecs[v].name, "_stallCnt"}, bus.StallCount, {31'd0, vecs[v].sD});
      check({vecs[v].name, "_flushCnt"}, bus.FlushCount, {31'd0, vecs[v].br});
    end

    // Bubble held by StallD stays a bubble
    doReset();
    bus.InstrF = INSTR_A;
    step();
    step();
    bus.FlushD = 1;
    step();
    bus.FlushD = 0;
    bus.StallD = 1;
    step();
    check("bubbleHold_instrD", bus.InstrD, NOP);
    check("bubbleHold_validD", bus.ValidD, 1'b0);
    check("bubbleHold_pcD", {bus.PCD, bus.PCPlus4D}, 64'h0);
    check("bubbleHold_validE", bus.ValidE, 1'b0);

    // Asynchronous reset during a stall
    doReset();
    bus.InstrF = INSTR_A;
    step();
    step();
    bus.StallD = 1;
    bus.StallF = 1;
    step();
    check("asyncRst_pre_stallCnt", bus.StallCount, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("asyncRst_pcf", bus.PCF, 32'h0);
    check("asyncRst_instrD", bus.InstrD, NOP);
    check("asyncRst_valid", {bus.ValidD, bus.ValidE}, 2'b00);
    check("asyncRst_rdE", bus.RdE, 5'd0);
    check("asyncRst_counts", {bus.StallCount, bus.FlushCount}, 64'h0);
    check("asyncRst_wrap_pcf", busW.PCF, 32'hFFFF_FFFC);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
